// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings and the ALU control type shared by the
// decode and execute stages of the five-stage MIPS pipeline.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLT = 3'd2
  } aluctr_t;

endpackage

// File: rtl/id_stage_p_if.sv
// id_stage_p_if: bundle of the decode stage's fetch, writeback, EX-feedback
// and decode/execute-register signals.
//   slave  : used by id_stage_p (fetch/wb/ex inputs, id_*/dx_* outputs)
//   master : used by the surrounding pipeline or a testbench
interface id_stage_p_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int PC_W   = 32
);
  localparam int RA_W = $clog2(NREGS);

  logic              if_valid;
  logic [31:0]       if_ir;
  logic [PC_W-1:0]   if_pc;
  logic              id_stall;
  logic              id_redirect;
  logic [PC_W-1:0]   id_target;
  logic              wb_we;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_lw;
  logic [RA_W-1:0]   ex_rd;
  logic              dx_valid;
  logic [DATA_W-1:0] dx_a;
  logic [DATA_W-1:0] dx_b;
  logic [DATA_W-1:0] dx_st;
  logic [RA_W-1:0]   dx_rd;
  logic [2:0]        dx_aluctr;
  logic              dx_lw;
  logic              dx_sw;
  logic              id_illegal;

  modport slave (
    input  if_valid, if_ir, if_pc, wb_we, wb_rd, wb_data, ex_lw, ex_rd,
    output id_stall, id_redirect, id_target, dx_valid, dx_a, dx_b, dx_st,
           dx_rd, dx_aluctr, dx_lw, dx_sw, id_illegal
  );

  modport master (
    output if_valid, if_ir, if_pc, wb_we, wb_rd, wb_data, ex_lw, ex_rd,
    input  id_stall, id_redirect, id_target, dx_valid, dx_a, dx_b, dx_st,
           dx_rd, dx_aluctr, dx_lw, dx_sw, id_illegal
  );
endinterface

// File: rtl/regfile_wt.sv
// regfile_wt: NREGS x DATA_W register file, one write port, two
// combinational write-through read ports, synchronous clear.
//   clk, rst        : clock, synchronous active-high clear of all entries
//   we_i, wa_i, wd_i: write port (writes to register 0 are dropped)
//   ra1_i/rd1_o     : read port 1
//   ra2_i/rd2_o     : read port 2
module regfile_wt #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(NREGS)-1:0]   wa_i,
  input  logic [DATA_W-1:0]          wd_i,
  input  logic [$clog2(NREGS)-1:0]   ra1_i,
  output logic [DATA_W-1:0]          rd1_o,
  input  logic [$clog2(NREGS)-1:0]   ra2_i,
  output logic [DATA_W-1:0]          rd2_o
);
  localparam int RA_W = $clog2(NREGS);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Storage: clear on reset, otherwise write any nonzero register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != RA_W'(0))) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Read ports: $0 is hard zero; a same-cycle write to the read index wins.
  always_comb begin
    if (ra1_i == RA_W'(0)) begin
      rd1_o = '0;
    end else if (we_i && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i];
    end
    if (ra2_i == RA_W'(0)) begin
      rd2_o = '0;
    end else if (we_i && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i];
    end
  end
endmodule

// File: rtl/id_stage_p.sv
// id_stage_p: MIPS instruction-decode stage. Decodes add/sub/slt/lw/sw/beq/j,
// reads operands through a write-through register file, stalls on load-use,
// resolves beq/j in-stage with a redirect, and registers one op into EX.
//   clk, rst : clock, synchronous active-high reset
//   bus      : id_stage_p_if.slave (fetch, writeback, EX feedback, dx register)
module id_stage_p #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int PC_W   = 32
) (
  input logic         clk,
  input logic         rst,
  id_stage_p_if.slave bus
);
  import mips_pkg::*;

  localparam int RA_W = $clog2(NREGS);

  logic [5:0]        op_s, fn_s;
  logic [4:0]        rs_s, rt_s, rd_s, ex_rd5_s;
  logic [15:0]       imm_s;
  logic [DATA_W-1:0] imm_x_s, ra_s, rb_s;
  logic [PC_W-1:0]   pc4_s, br_tgt_s, j_tgt_s;
  logic              is_r_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, fn_ok_s;
  aluctr_t           alu_s;
  logic              hi_rs_s, hi_rt_s, hi_rd_s, legal_s;
  logic              hazard_s, go_s, issue_s, redirect_s;
  logic              unused_ok;

  logic              dx_valid_d, dx_valid_q, dx_lw_d, dx_lw_q, dx_sw_d, dx_sw_q;
  logic              ill_d, ill_q;
  logic [DATA_W-1:0] dx_a_d, dx_a_q, dx_b_d, dx_b_q, dx_st_d, dx_st_q;
  logic [RA_W-1:0]   dx_rd_d, dx_rd_q;
  aluctr_t           dx_aluctr_d, dx_aluctr_q;

  assign op_s      = bus.if_ir[31:26];
  assign rs_s      = bus.if_ir[25:21];
  assign rt_s      = bus.if_ir[20:16];
  assign rd_s      = bus.if_ir[15:11];
  assign fn_s      = bus.if_ir[5:0];
  assign imm_s     = bus.if_ir[15:0];
  assign unused_ok = ^bus.if_ir[10:6];
  assign imm_x_s   = DATA_W'($signed(imm_s));

  regfile_wt #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk  (clk),
    .rst  (rst),
    .we_i (bus.wb_we),
    .wa_i (bus.wb_rd),
    .wd_i (bus.wb_data),
    .ra1_i(rs_s[RA_W-1:0]),
    .rd1_o(ra_s),
    .ra2_i(rt_s[RA_W-1:0]),
    .rd2_o(rb_s)
  );

  // Opcode/funct classification and ALU op selection.
  always_comb begin
    is_r_s = 1'b0; is_lw_s = 1'b0; is_sw_s = 1'b0;
    is_beq_s = 1'b0; is_j_s = 1'b0; fn_ok_s = 1'b0;
    alu_s = ALU_ADD;
    case (op_s)
      OP_RTYPE: begin
        is_r_s = 1'b1;
        case (fn_s)
          FN_ADD:  begin fn_ok_s = 1'b1; alu_s = ALU_ADD; end
          FN_SUB:  begin fn_ok_s = 1'b1; alu_s = ALU_SUB; end
          FN_SLT:  begin fn_ok_s = 1'b1; alu_s = ALU_SLT; end
          default: begin fn_ok_s = 1'b0; alu_s = ALU_ADD; end
        endcase
      end
      OP_LW:   is_lw_s  = 1'b1;
      OP_SW:   is_sw_s  = 1'b1;
      OP_BEQ:  is_beq_s = 1'b1;
      OP_J:    is_j_s   = 1'b1;
      default: is_r_s   = 1'b0;
    endcase
  end

  // Register fields naming a register beyond NREGS make the word undecodable.
  assign hi_rs_s = (rs_s >> RA_W) != 5'd0;
  assign hi_rt_s = (rt_s >> RA_W) != 5'd0;
  assign hi_rd_s = (rd_s >> RA_W) != 5'd0;
  assign legal_s = (is_r_s && fn_ok_s && !hi_rs_s && !hi_rt_s && !hi_rd_s)
                || ((is_lw_s || is_sw_s || is_beq_s) && !hi_rs_s && !hi_rt_s)
                || is_j_s;

  // Load-use: rs is a source for everything but j, rt for R-type/sw/beq.
  // Compared at full 5-bit width so out-of-range fields never alias.
  assign ex_rd5_s = 5'(bus.ex_rd);
  assign hazard_s = bus.ex_lw && (ex_rd5_s != 5'd0)
                 && ((!is_j_s && (rs_s == ex_rd5_s))
                  || ((is_r_s || is_sw_s || is_beq_s) && (rt_s == ex_rd5_s)));

  assign go_s        = !rst && bus.if_valid && !hazard_s;
  assign issue_s     = go_s && legal_s && (is_r_s || is_lw_s || is_sw_s);
  assign redirect_s  = go_s && (is_j_s || (is_beq_s && legal_s && (ra_s == rb_s)));
  assign bus.id_stall    = !rst && bus.if_valid && hazard_s;
  assign bus.id_redirect = redirect_s;

  // Branch/jump targets; the j region bits come from pc+4 above bit 27.
  assign pc4_s    = bus.if_pc + PC_W'(32'd4);
  assign br_tgt_s = pc4_s + (PC_W'($signed(imm_s)) << 2);
  assign j_tgt_s  = (pc4_s & ~PC_W'(32'h0FFF_FFFF)) | PC_W'({bus.if_ir[25:0], 2'b00});
  assign bus.id_target = redirect_s ? (is_j_s ? j_tgt_s : br_tgt_s) : PC_W'(32'd0);

  // Next dx register contents; every non-issue cycle is an all-zero bubble.
  always_comb begin
    dx_valid_d = 1'b0; dx_a_d = '0; dx_b_d = '0; dx_st_d = '0;
    dx_rd_d = '0; dx_aluctr_d = ALU_ADD; dx_lw_d = 1'b0; dx_sw_d = 1'b0;
    ill_d = go_s && !legal_s;
    if (issue_s) begin
      dx_valid_d  = 1'b1;
      dx_a_d      = ra_s;
      dx_aluctr_d = alu_s;
      if (is_r_s) begin
        dx_b_d  = rb_s;
        dx_rd_d = rd_s[RA_W-1:0];
      end else if (is_lw_s) begin
        dx_b_d  = imm_x_s;
        dx_rd_d = rt_s[RA_W-1:0];
        dx_lw_d = 1'b1;
      end else begin
        dx_b_d  = imm_x_s;
        dx_st_d = rb_s;
        dx_sw_d = 1'b1;
      end
    end else begin
      dx_valid_d = 1'b0;
    end
  end

  // Decode/execute pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_valid_q <= 1'b0; dx_a_q <= '0; dx_b_q <= '0; dx_st_q <= '0;
      dx_rd_q <= '0; dx_aluctr_q <= ALU_ADD; dx_lw_q <= 1'b0; dx_sw_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      dx_valid_q <= dx_valid_d; dx_a_q <= dx_a_d; dx_b_q <= dx_b_d;
      dx_st_q <= dx_st_d; dx_rd_q <= dx_rd_d; dx_aluctr_q <= dx_aluctr_d;
      dx_lw_q <= dx_lw_d; dx_sw_q <= dx_sw_d; ill_q <= ill_d;
    end
  end

  assign bus.dx_valid   = dx_valid_q;
  assign bus.dx_a       = dx_a_q;
  assign bus.dx_b       = dx_b_q;
  assign bus.dx_st      = dx_st_q;
  assign bus.dx_rd      = dx_rd_q;
  assign bus.dx_aluctr  = dx_aluctr_q;
  assign bus.dx_lw      = dx_lw_q;
  assign bus.dx_sw      = dx_sw_q;
  assign bus.id_illegal = ill_q;
endmodule

// File: tb/tb_id_stage_p.sv
// Testbench for id_stage_p: directed cases plus randomized stimulus against
// a behavioural decode model; expected dx records go through a scoreboard.
module tb_id_stage_p;
  typedef struct packed {
    logic        v;
    logic [31:0] a, b, st;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic        lw, sw, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rst2;

  id_stage_p_if #(.DATA_W(32), .NREGS(32), .PC_W(32)) b1();
  id_stage_p_if #(.DATA_W(16), .NREGS(8),  .PC_W(32)) b2();

  id_stage_p #(.DATA_W(32), .NREGS(32), .PC_W(32)) dut1 (.clk(clk), .rst(rst),  .bus(b1));
  id_stage_p #(.DATA_W(16), .NREGS(8),  .PC_W(32)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

  always #5 clk = ~clk;

  exp_t        sbq[$];
  logic [31:0] mref [32];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          exp_stall, exp_redir;
  logic [31:0] exp_tgt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural register read as the decoder should see it this cycle.
  function automatic logic [31:0] rv(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (b1.wb_we && b1.wb_rd == i) return b1.wb_data;
    return mref[i];
  endfunction

  // Drive one cycle of inputs, predict the outcome, check combinational outputs.
  task automatic apply(input bit r, input bit v, input logic [31:0] ir, input logic [31:0] pc,
                       input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                       input bit exl, input logic [4:0] exrd);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [31:0] sx, a, bv, p4;
    bit urs, urt, haz;
    rst = r; b1.if_valid = v; b1.if_ir = ir; b1.if_pc = pc;
    b1.wb_we = we; b1.wb_rd = wrd; b1.wb_data = wd; b1.ex_lw = exl; b1.ex_rd = exrd;
    op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    sx = 32'($signed(ir[15:0]));
    a = rv(rs); bv = rv(rt); p4 = pc + 32'd4;
    urs = (op != 6'd2);
    urt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
    haz = exl && (exrd != 5'd0) && ((urs && rs == exrd) || (urt && rt == exrd));
    e = '0; exp_stall = 1'b0; exp_redir = 1'b0; exp_tgt = 32'd0;
    if (!r && v) begin
      if (haz) exp_stall = 1'b1;
      else begin
        case (op)
          6'd0: begin
            if (fn == 6'd32 || fn == 6'd34 || fn == 6'd42) begin
              e.v = 1'b1; e.a = a; e.b = bv; e.rd = rd;
              e.alu = (fn == 6'd32) ? 3'd0 : (fn == 6'd34) ? 3'd1 : 3'd2;
            end else e.ill = 1'b1;
          end
          6'd35: begin e.v = 1'b1; e.a = a; e.b = sx; e.rd = rt; e.lw = 1'b1; end
          6'd43: begin e.v = 1'b1; e.a = a; e.b = sx; e.st = bv; e.sw = 1'b1; end
          6'd4: if (a == bv) begin exp_redir = 1'b1; exp_tgt = p4 + sx * 32'd4; end
          6'd2: begin
            exp_redir = 1'b1;
            exp_tgt = (p4 / 32'h1000_0000) * 32'h1000_0000 + {6'd0, ir[25:0]} * 32'd4;
          end
          default: e.ill = 1'b1;
        endcase
      end
    end
    sbq.push_back(e);
    #1;
    chk("id_stall", {31'd0, b1.id_stall}, {31'd0, exp_stall});
    chk("id_redirect", {31'd0, b1.id_redirect}, {31'd0, exp_redir});
    if (exp_redir) chk("id_target", b1.id_target, exp_tgt);
  endtask

  // Commit this cycle's register-file effect to the model and advance.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < 32; i++) mref[i] = 32'd0;
    end else if (b1.wb_we && b1.wb_rd != 5'd0) begin
      mref[b1.wb_rd] = b1.wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit we, input logic [4:0] wrd, input logic [31:0] wd);
    apply(1'b0, 1'b0, 32'd0, 32'd0, we, wrd, wd, 1'b0, 5'd0);
    step();
  endtask

  // Monitor: the record pushed one cycle earlier describes the current dx register.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      chk("dx_valid",   {31'd0, b1.dx_valid},   {31'd0, e.v});
      chk("dx_a",       b1.dx_a,                e.a);
      chk("dx_b",       b1.dx_b,                e.b);
      chk("dx_st",      b1.dx_st,               e.st);
      chk("dx_rd",      {27'd0, b1.dx_rd},      {27'd0, e.rd});
      chk("dx_aluctr",  {29'd0, b1.dx_aluctr},  {29'd0, e.alu});
      chk("dx_lw",      {31'd0, b1.dx_lw},      {31'd0, e.lw});
      chk("dx_sw",      {31'd0, b1.dx_sw},      {31'd0, e.sw});
      chk("id_illegal", {31'd0, b1.id_illegal}, {31'd0, e.ill});
    end
  end

  initial begin
    logic [31:0] ir, pc, wd;
    logic [4:0] rs, rt, rd, wrd, exrd;
    int sel;
    rst2 = 1'b1;
    b2.if_valid = 1'b0; b2.if_ir = 32'd0; b2.if_pc = 32'd0; b2.wb_we = 1'b0;
    b2.wb_rd = 3'd0; b2.wb_data = 16'd0; b2.ex_lw = 1'b0; b2.ex_rd = 3'd0;

    // Reset
    apply(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    apply(1'b1, 1'b1, r_ins(5'd1, 5'd1, 5'd2, 6'd32), 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();

    // Write-through: add $3,$5,$0 while $5 <- 0x1234
    apply(1'b0, 1'b1, r_ins(5'd5, 5'd0, 5'd3, 6'd32), 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0); step();

    // Sign extension: lw $7,-4($2) with R2 = 0x100
    idle(1'b1, 5'd2, 32'h100);
    apply(1'b0, 1'b1, i_ins(6'd35, 5'd2, 5'd7, 16'hFFFC), 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();

    // Load-use on $4, then release
    apply(1'b0, 1'b1, r_ins(5'd2, 5'd4, 5'd1, 6'd34), 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    chk("loaduse_stall", {31'd0, b1.id_stall}, 32'd1);
    step();
    apply(1'b0, 1'b1, r_ins(5'd2, 5'd4, 5'd1, 6'd34), 32'd8, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();

    // beq taken / not taken, j
    idle(1'b1, 5'd1, 32'd9);
    idle(1'b1, 5'd2, 32'd9);
    apply(1'b0, 1'b1, i_ins(6'd4, 5'd1, 5'd2, 16'd3), 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("beq_target", b1.id_target, 32'h50);
    step();
    idle(1'b1, 5'd2, 32'd8);
    apply(1'b0, 1'b1, i_ins(6'd4, 5'd1, 5'd2, 16'd3), 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("beq_not_taken", {31'd0, b1.id_redirect}, 32'd0);
    step();
    apply(1'b0, 1'b1, {6'd2, 26'h100}, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("j_target", b1.id_target, 32'h400);
    step();

    // Illegal opcode pulses once
    apply(1'b0, 1'b1, {6'd63, 26'd0}, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    idle(1'b0, 5'd0, 32'd0);

    // Writes to $0 are dropped, same cycle and afterwards
    apply(1'b0, 1'b1, r_ins(5'd0, 5'd0, 5'd3, 6'd32), 32'd0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0); step();
    apply(1'b0, 1'b1, r_ins(5'd0, 5'd0, 5'd1, 6'd32), 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();

    // Reset during a stall
    idle(1'b1, 5'd5, 32'd7);
    apply(1'b0, 1'b1, r_ins(5'd2, 5'd4, 5'd1, 6'd34), 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4); step();
    apply(1'b1, 1'b1, r_ins(5'd2, 5'd4, 5'd1, 6'd34), 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4); step();
    apply(1'b0, 1'b1, r_ins(5'd5, 5'd2, 5'd3, 6'd32), 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      sel = $urandom_range(0, 9);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      case (sel)
        0, 9: ir = r_ins(rs, rt, rd, 6'd32);
        1:    ir = r_ins(rs, rt, rd, 6'd34);
        2:    ir = r_ins(rs, rt, rd, 6'd42);
        3:    ir = r_ins(rs, rt, rd, 6'($urandom_range(0, 63)));
        4:    ir = i_ins(6'd35, rs, rt, 16'($urandom));
        5:    ir = i_ins(6'd43, rs, rt, 16'($urandom));
        6:    ir = i_ins(6'd4, rs, rt, 16'($urandom));
        7:    ir = {6'd2, 26'($urandom)};
        default: ir = $urandom;
      endcase
      pc = $urandom; pc[1:0] = 2'b00;
      wrd = 5'($urandom_range(0, 7));
      wd = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      exrd = 5'($urandom_range(0, 7));
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 6) != 0, ir, pc,
            $urandom_range(0, 1) == 1, wrd, wd, $urandom_range(0, 3) == 0, exrd);
      step();
    end
    repeat (3) idle(1'b0, 5'd0, 32'd0);

    // Narrow configuration: DATA_W=16, NREGS=8
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    b2.if_valid = 1'b1; b2.if_ir = r_ins(5'd1, 5'd2, 5'd9, 6'd32);
    @(posedge clk); #1;
    chk("n8_illegal", {31'd0, b2.id_illegal}, 32'd1);
    chk("n8_ill_valid", {31'd0, b2.dx_valid}, 32'd0);
    b2.if_ir = i_ins(6'd35, 5'd0, 5'd1, 16'h8000);
    @(posedge clk); #1;
    chk("n8_lw_b", {16'd0, b2.dx_b}, 32'h8000);
    chk("n8_lw_rd", {29'd0, b2.dx_rd}, 32'd1);
    chk("n8_lw_flag", {31'd0, b2.dx_lw}, 32'd1);
    chk("n8_lw_valid", {31'd0, b2.dx_valid}, 32'd1);
    chk("n8_ill_drop", {31'd0, b2.id_illegal}, 32'd0);
    b2.if_valid = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode stage for the five-stage MIPS pipeline, placed between the fetch and execute stages. It adds the following to the first-generation decode:
- a reset-cleared register file with same-cycle write-through;
- sign-extended immediates;
- load-use hazard stall;
- in-stage resolution of `beq`/`j` with redirect;
- a valid bit on the decode/execute register.

It decodes add/sub/slt/lw/sw/beq/j and launches one operation per cycle into EX.

## Interface
- `DATA_W`, 32: datapath and register width, ≥ 16.
- `NREGS`, 32: register count, power of two, 8..32. `RA_W` = `$clog2(NREGS)`.
- `PC_W`, 32: program-counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_valid` in 1: `if_ir`/`if_pc` hold a real instruction.
- `if_ir` in 32: instruction word.
- `if_pc` in `PC_W`: address of `if_ir`.
- `id_stall` out 1: combinational; fetch must hold `if_ir`/`if_pc`.
- `id_redirect` out 1: combinational; taken beq or j; fetch loads `id_target`, discards the next fetched word.
- `id_target` out `PC_W`: combinational redirect address.
- `wb_we` in 1: writeback enable.
- `wb_rd` in `RA_W`: writeback register.
- `wb_data` in `DATA_W`: writeback value.
- `ex_lw` in 1: the instruction currently in EX is a valid lw.
- `ex_rd` in `RA_W`: destination of that instruction.
- `dx_valid` out 1: registered; EX operation is real.
- `dx_a` out `DATA_W`: registered rs operand.
- `dx_b` out `DATA_W`: registered rt value (R-type) or sign-extended imm (lw/sw).
- `dx_st` out `DATA_W`: registered rt value, the store data for sw; 0 otherwise.
- `dx_rd` out `RA_W`: registered destination.
- `dx_aluctr` out 3: registered ALU op.
- `dx_lw` out 1: registered load flag.
- `dx_sw` out 1: registered store flag.
- `id_illegal` out 1: registered one-cycle pulse for an undecodable valid instruction.

## Operation
- Register file: `NREGS` × `DATA_W`.
  - All entries clear to 0 on `rst`.
  - Write on `clk` when `wb_we` and `wb_rd`≠0. Register 0 always reads 0.
  - Reads are write-through: if `wb_we` and `wb_rd` equals the read index (≠0), the read returns `wb_data` in the same cycle.
- Field decode: rs=`if_ir[25:21]`, rt=`[20:16]`, rd=`[15:11]`, imm=`[15:0]`, sign-extended to `DATA_W`.
  - If `NREGS`<32, any nonzero register-field bit at or above bit `RA_W` is illegal.
- Decode, per instruction:
  - add (op 0, funct 32): aluctr 0.
  - sub (funct 34): aluctr 1.
  - slt (funct 42): aluctr 2.
  - R-type operands: `dx_b`=R[rt], `dx_rd`=rd, `dx_st`=0.
  - lw (op 35): `dx_b`=sext(imm), `dx_rd`=rt, aluctr 0, `dx_lw`=1.
  - sw (op 43): `dx_b`=sext(imm), `dx_st`=R[rt], `dx_rd`=0, aluctr 0, `dx_sw`=1.
  - beq (op 4): compares write-through R[rs] and R[rt]. If equal, `id_redirect`=1 and `id_target`=`if_pc`+4+(sext(imm)<<2), modulo 2^`PC_W`.
  - j (op 2): `id_redirect`=1, `id_target`={(`if_pc`+4)[PC_W-1:28], `if_ir[25:0]`, 2'b00}.
  - beq and j launch a bubble into EX.
  - Any other opcode or funct: bubble, and `id_illegal` pulses.
- Load-use hazard, evaluated combinationally:
  - The instruction's sources are: rs for all types except j; rt for R-type, sw and beq.
  - `id_stall`=`if_valid`·`ex_lw`·(`ex_rd`≠0)·(`ex_rd` matches any source).
  - During a stall: bubble into EX, `id_redirect`=0, `id_illegal` not raised.
- Bubble: `dx_valid`=0, `dx_lw`=`dx_sw`=0, `dx_rd`=0. Other dx fields don't-care and are driven 0.
- Precedence, highest first: `rst` > `!if_valid` (bubble) > stall > decode/redirect.

## Timing
- Latency: 1 cycle from `if_ir` to the dx outputs.
- `id_stall`, `id_redirect` and `id_target` are same-cycle combinational.
- Stall: exactly one bubble per load-use. The next cycle, `ex_lw` drops and the held instruction issues.
- Reset: on the first edge with `rst`=1, all dx outputs and `id_illegal` go 0 and the register file is cleared.
  - `id_stall`/`id_redirect` are forced 0 while `rst`=1.
  - A `rst` arriving mid-stall discards the held instruction's pending issue.
- `if_valid`=0: `id_stall`/`id_redirect`=0 regardless of `if_ir`.
- Simultaneous WB write and ID read of the same register: the decode sees the new value.
- Simultaneous WB write to rd=0: ignored.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants `OP_RTYPE`=0, `OP_J`=2, `OP_BEQ`=4, `OP_LW`=35, `OP_SW`=43;
  - funct constants `FN_ADD`=32, `FN_SUB`=34, `FN_SLT`=42;
  - typedef `aluctr_t` (3-bit: `ALU_ADD`=0, `ALU_SUB`=1, `ALU_SLT`=2), which EX shares.
- One sub-module: `regfile_wt` (parameters `DATA_W`, `NREGS`), two write-through read ports, one write port, synchronous clear.
- Decode, hazard and branch logic live in `id_stage_p`.

## Test plan
- **Write-through:** `wb_we`=1, `wb_rd`=5, `wb_data`=0x1234, same cycle add $3,$5,$0 → next cycle `dx_a`=0x1234, `dx_b`=0, `dx_rd`=3, `dx_aluctr`=0, `dx_valid`=1.
- **Sign extension:** lw $7,-4($2) with R2=0x100 → `dx_a`=0x100, `dx_b`=0xFFFFFFFC, `dx_rd`=7, `dx_lw`=1.
- **Load-use:** `ex_lw`=1, `ex_rd`=4, ID holds sub $1,$2,$4 → `id_stall`=1 and a bubble. Drop `ex_lw` → sub issues the following cycle with `dx_aluctr`=1.
- **Redirects:**
  - beq $1,$2,+3 at pc 0x40 with R1=R2=9 → `id_redirect`=1, `id_target`=0x50, bubble.
  - Same with R2=8 → no redirect.
  - j 0x100 at pc 0x40 → `id_target`=0x400.
- **Illegal, $0, reset:**
  - op 63 → `id_illegal` pulses once, `dx_valid`=0.
  - Write 0xFF to $0, then read $0 → 0.
  - Assert `rst` during a stall → all dx outputs 0, registers read 0.
- **Parameter sweep:** `DATA_W`=16, `NREGS`=8 → add $9,… flagged illegal; lw imm 0x8000 → `dx_b`=0x8000.
